// File: rtl/sig_capture.sv
// Sample decimator: averages 2^dshift accepted samples into one output with a one-cycle en strobe.
// Optional peak tracking of emitted values is enabled by defining SIGCAP_PEAK_EN.
module sig_capture #(
  parameter int unsigned D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic [1:0]         dshift,
  output logic [D_WIDTH-1:0] signal,
  output logic               en
`ifdef SIGCAP_PEAK_EN
  ,
  output logic [D_WIDTH-1:0] peak,
  input  logic               peak_clr
`endif
);

  // Three extra bits hold the sum of up to eight full-scale samples.
  localparam int unsigned A_WIDTH = D_WIDTH + 3;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [A_WIDTH-1:0] r_acc, w_acc_nxt, w_sum;
  logic [2:0]         r_cnt, w_cnt_nxt, w_last_cnt;
  logic [1:0]         r_ratio, w_ratio_nxt, w_ratio;
  logic [D_WIDTH-1:0] r_signal, w_signal_nxt;
  logic               r_en, w_en_nxt;
  logic               w_xfer;

  assign in_ready = (r_state == ACCUM) && !rst;
  assign w_xfer   = in_valid && in_ready;

  // The first sample of a block uses the live dshift; later samples use the latched ratio.
  assign w_ratio    = (r_cnt == 3'd0) ? dshift : r_ratio;
  assign w_last_cnt = 3'((4'd1 << w_ratio) - 4'd1);
  assign w_sum      = r_acc + A_WIDTH'(in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ACCUM;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ratio  <= '0;
      r_signal <= '0;
      r_en     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ratio  <= w_ratio_nxt;
      r_signal <= w_signal_nxt;
      r_en     <= w_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_ratio_nxt  = r_ratio;
    w_signal_nxt = r_signal;
    w_en_nxt     = 1'b0;
    case (r_state)
      ACCUM: begin
        if (w_xfer) begin
          w_ratio_nxt = w_ratio;
          if (r_cnt == w_last_cnt) begin
            w_signal_nxt = D_WIDTH'(w_sum >> w_ratio);
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
            w_en_nxt     = 1'b1;
            w_state_nxt  = EMIT;
          end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end
      EMIT:    w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  assign signal = r_signal;
  assign en     = r_en;

`ifdef SIGCAP_PEAK_EN
  logic [D_WIDTH-1:0] r_peak;

  // Clear wins over a coincident update from the emitted value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak <= '0;
    end else if (peak_clr) begin
      r_peak <= '0;
    end else if (r_en && (r_signal > r_peak)) begin
      r_peak <= r_signal;
    end
  end

  assign peak = r_peak;
`endif

endmodule
